// File: rtl/rv_pkg.sv
// rtl/rv_pkg.sv - shared RISC-V opcode constants and immediate format encoding
package rv_pkg;

    localparam logic [6:0] LOAD      = 7'b0000011;
    localparam logic [6:0] MISC_MEM  = 7'b0001111;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] AUIPC     = 7'b0010111;
    localparam logic [6:0] OP_IMM_32 = 7'b0011011;
    localparam logic [6:0] STORE     = 7'b0100011;
    localparam logic [6:0] OP        = 7'b0110011;
    localparam logic [6:0] LUI       = 7'b0110111;
    localparam logic [6:0] OP_32     = 7'b0111011;
    localparam logic [6:0] BRANCH    = 7'b1100011;
    localparam logic [6:0] JALR      = 7'b1100111;
    localparam logic [6:0] JAL       = 7'b1101111;
    localparam logic [6:0] SYSTEM    = 7'b1110011;

    typedef enum logic [2:0] {
        FMT_NONE  = 3'd0,
        FMT_I     = 3'd1,
        FMT_S     = 3'd2,
        FMT_B     = 3'd3,
        FMT_U     = 3'd4,
        FMT_J     = 3'd5,
        FMT_SHAMT = 3'd6
    } fmt_t;

endpackage

// File: rtl/imm_decode.sv
// rtl/imm_decode.sv - combinational instruction word to immediate/format/illegal decode
module imm_decode
    import rv_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [31:0]     ir,
    output logic [XLEN-1:0] imm,
    output fmt_t            fmt,
    output logic            illegal
);

    logic shamt6;

    always_comb begin
        fmt     = FMT_NONE;
        illegal = 1'b0;
        shamt6  = 1'b0;
        case (ir[6:0])
            LOAD, JALR, MISC_MEM, SYSTEM: fmt = FMT_I;
            OP_IMM: begin
                fmt    = (ir[13:12] == 2'b01) ? FMT_SHAMT : FMT_I;
                shamt6 = (XLEN == 64);
            end
            OP_IMM_32: begin
                if (XLEN == 32) illegal = 1'b1;
                else            fmt = (ir[13:12] == 2'b01) ? FMT_SHAMT : FMT_I;
            end
            STORE:       fmt = FMT_S;
            BRANCH:      fmt = FMT_B;
            LUI, AUIPC:  fmt = FMT_U;
            JAL:         fmt = FMT_J;
            OP:          fmt = FMT_NONE;
            OP_32:       illegal = (XLEN == 32);
            default:     illegal = 1'b1;
        endcase
    end

    // U keeps ir[31] as its own sign bit so the replication never collapses to zero width
    always_comb begin
        imm = '0;
        case (fmt)
            FMT_I:     imm = {{(XLEN-12){ir[31]}}, ir[31:20]};
            FMT_S:     imm = {{(XLEN-12){ir[31]}}, ir[31:25], ir[11:7]};
            FMT_B:     imm = {{(XLEN-12){ir[31]}}, ir[7], ir[30:25], ir[11:8], 1'b0};
            FMT_U:     imm = {{(XLEN-31){ir[31]}}, ir[30:12], 12'b0};
            FMT_J:     imm = {{(XLEN-20){ir[31]}}, ir[19:12], ir[20], ir[30:21], 1'b0};
            FMT_SHAMT: imm = shamt6 ? XLEN'(ir[25:20]) : XLEN'(ir[24:20]);
            default:   imm = '0;
        endcase
    end

endmodule

// File: rtl/imm_gen_stage.sv
// rtl/imm_gen_stage.sv - registered immediate generator with PC-relative target and optional skid buffer
module imm_gen_stage
    import rv_pkg::*;
#(
    parameter int XLEN = 32,
    parameter bit SKID = 1'b1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     in_ir,
    input  logic [XLEN-1:0] in_pc,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [31:0]     out_ir,
    output logic [XLEN-1:0] out_pc,
    output logic [XLEN-1:0] out_imm,
    output logic [2:0]      out_fmt,
    output logic [XLEN-1:0] out_target,
    output logic            out_illegal
);

    typedef struct packed {
        logic [31:0]     ir;
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] imm;
        fmt_t            fmt;
        logic [XLEN-1:0] target;
        logic            illegal;
    } entry_t;

    logic [XLEN-1:0] dec_imm;
    fmt_t            dec_fmt;
    logic            dec_illegal;
    logic            pc_rel;
    entry_t          din;
    entry_t          head;
    logic            head_valid;

    imm_decode #(.XLEN(XLEN)) u_dec (
        .ir      (in_ir),
        .imm     (dec_imm),
        .fmt     (dec_fmt),
        .illegal (dec_illegal)
    );

    // AUIPC shares the U format with LUI, so it is told apart by opcode
    assign pc_rel = (dec_fmt == FMT_B) || (dec_fmt == FMT_J) || (in_ir[6:0] == AUIPC);

    always_comb begin
        din.ir      = in_ir;
        din.pc      = in_pc;
        din.imm     = dec_imm;
        din.fmt     = dec_fmt;
        din.illegal = dec_illegal;
        din.target  = in_pc + (pc_rel ? dec_imm : XLEN'(4));
    end

    generate
        if (SKID) begin : g_skid
            typedef enum logic [1:0] {EMPTY, ONE, FULL} state_t;

            state_t state, state_n;
            entry_t e0, e1;
            logic   rdy_r;
            logic   accept;

            assign accept = in_valid && rdy_r;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    state <= EMPTY;
                    rdy_r <= 1'b1;
                end else begin
                    state <= state_n;
                    rdy_r <= (state_n != FULL);
                end
            end

            always_comb begin
                state_n = state;
                if (flush) begin
                    state_n = EMPTY;
                end else begin
                    case (state)
                        EMPTY: if (accept) state_n = ONE;
                        ONE: begin
                            if (accept && !out_ready)      state_n = FULL;
                            else if (!accept && out_ready) state_n = EMPTY;
                        end
                        FULL:    if (out_ready) state_n = ONE;
                        default: state_n = EMPTY;
                    endcase
                end
            end

            // e0 is always the head; e1 only holds the second entry while FULL
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    e0 <= '0;
                    e1 <= '0;
                end else if (!flush) begin
                    case (state)
                        EMPTY: if (accept) e0 <= din;
                        ONE: begin
                            if (accept) begin
                                if (out_ready) e0 <= din;
                                else           e1 <= din;
                            end
                        end
                        FULL:    if (out_ready) e0 <= e1;
                        default: ;
                    endcase
                end
            end

            always_comb begin
                head_valid = (state != EMPTY);
                head       = e0;
            end

            assign in_ready = rdy_r;
        end else begin : g_single
            entry_t r;
            logic   v;

            assign in_ready = !v || out_ready;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r <= '0;
                    v <= 1'b0;
                end else if (flush) begin
                    v <= 1'b0;
                end else if (in_valid && in_ready) begin
                    v <= 1'b1;
                    r <= din;
                end else if (out_ready) begin
                    v <= 1'b0;
                end
            end

            assign head_valid = v;
            assign head       = r;
        end
    endgenerate

    assign out_valid   = head_valid;
    assign out_ir      = head.ir;
    assign out_pc      = head.pc;
    assign out_imm     = head.imm;
    assign out_fmt     = head.fmt;
    assign out_target  = head.target;
    assign out_illegal = head.illegal;

endmodule

// File: tb/tb_imm_gen_stage.sv
// tb/tb_imm_gen_stage.sv - self-checking bench for imm_gen_stage (RV32 skid, RV64 skid, RV32 single)
module tb_imm_gen_stage;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        flush = 1'b0;
    logic        in_valid = 1'b0;
    logic        out_ready = 1'b1;
    logic [31:0] in_ir = '0;
    logic [63:0] in_pc = '0;

    logic        r0, v0, il0, r1, v1, il1, r2, v2, il2;
    logic [31:0] ir0, ir1, ir2;
    logic [31:0] pc0, imm0, tg0, pc2, imm2, tg2;
    logic [63:0] pc1, imm1, tg1;
    logic [2:0]  fmt0, fmt1, fmt2;

    logic        a_rdy [3];
    logic        a_val [3];
    logic        a_il  [3];
    logic [31:0] a_ir  [3];
    logic [63:0] a_pc  [3];
    logic [63:0] a_imm [3];
    logic [63:0] a_tg  [3];
    logic [2:0]  a_fmt [3];

    int checks = 0;
    int errors = 0;
    bit chk_en = 1'b0;

    always #5 clk = ~clk;

    imm_gen_stage #(.XLEN(32), .SKID(1'b1)) u_d0 (
        .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(r0),
        .in_ir(in_ir), .in_pc(in_pc[31:0]), .out_valid(v0), .out_ready(out_ready),
        .out_ir(ir0), .out_pc(pc0), .out_imm(imm0), .out_fmt(fmt0), .out_target(tg0),
        .out_illegal(il0));

    imm_gen_stage #(.XLEN(64), .SKID(1'b1)) u_d1 (
        .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(r1),
        .in_ir(in_ir), .in_pc(in_pc), .out_valid(v1), .out_ready(out_ready),
        .out_ir(ir1), .out_pc(pc1), .out_imm(imm1), .out_fmt(fmt1), .out_target(tg1),
        .out_illegal(il1));

    imm_gen_stage #(.XLEN(32), .SKID(1'b0)) u_d2 (
        .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(r2),
        .in_ir(in_ir), .in_pc(in_pc[31:0]), .out_valid(v2), .out_ready(out_ready),
        .out_ir(ir2), .out_pc(pc2), .out_imm(imm2), .out_fmt(fmt2), .out_target(tg2),
        .out_illegal(il2));

    assign a_rdy[0] = r0;  assign a_rdy[1] = r1;  assign a_rdy[2] = r2;
    assign a_val[0] = v0;  assign a_val[1] = v1;  assign a_val[2] = v2;
    assign a_il[0]  = il0; assign a_il[1]  = il1; assign a_il[2]  = il2;
    assign a_ir[0]  = ir0; assign a_ir[1]  = ir1; assign a_ir[2]  = ir2;
    assign a_pc[0]  = {32'b0, pc0};  assign a_pc[1]  = pc1;  assign a_pc[2]  = {32'b0, pc2};
    assign a_imm[0] = {32'b0, imm0}; assign a_imm[1] = imm1; assign a_imm[2] = {32'b0, imm2};
    assign a_tg[0]  = {32'b0, tg0};  assign a_tg[1]  = tg1;  assign a_tg[2]  = {32'b0, tg2};
    assign a_fmt[0] = fmt0; assign a_fmt[1] = fmt1; assign a_fmt[2] = fmt2;

    typedef struct {
        logic [31:0] ir;
        logic [63:0] pc;
        logic [63:0] imm;
        logic [63:0] tg;
        logic [2:0]  fmt;
        logic        il;
    } exp_t;

    // Reference queue per DUT: capacity 2 for the skid versions, 1 for the single register
    exp_t mem  [3][4];
    int   cnt  [3] = '{0, 0, 0};
    logic rdyr [3] = '{1'b1, 1'b1, 1'b1};

    function automatic longint sx(longint val, int bits);
        if (((val >> (bits - 1)) & 1) != 0) return val - (longint'(1) << bits);
        return val;
    endfunction

    function automatic exp_t ref_model(logic [31:0] ir, logic [63:0] pc, int xlen);
        exp_t        e;
        longint      x, v;
        logic [63:0] mask;
        bit          rel;
        x    = {32'b0, ir};
        mask = (xlen == 64) ? 64'hFFFF_FFFF_FFFF_FFFF : 64'h0000_0000_FFFF_FFFF;
        v    = 0;
        rel  = 1'b0;
        e.ir = ir; e.pc = pc & mask; e.fmt = 3'd0; e.il = 1'b0;
        case (ir[6:0])
            7'h03, 7'h67, 7'h0F, 7'h73: begin e.fmt = 3'd1; v = sx(x >> 20, 12); end
            7'h13, 7'h1B: begin
                if (ir[6:0] == 7'h1B && xlen == 32) e.il = 1'b1;
                else if (ir[14:12] == 3'b001 || ir[14:12] == 3'b101) begin
                    e.fmt = 3'd6;
                    v = (xlen == 64 && ir[6:0] == 7'h13) ? ((x >> 20) & 63) : ((x >> 20) & 31);
                end else begin
                    e.fmt = 3'd1; v = sx(x >> 20, 12);
                end
            end
            7'h23: begin e.fmt = 3'd2; v = sx(((x >> 25) << 5) | ((x >> 7) & 31), 12); end
            7'h63: begin
                e.fmt = 3'd3; rel = 1'b1;
                v = sx(((x >> 31) << 12) | (((x >> 7) & 1) << 11) | (((x >> 25) & 63) << 5)
                       | (((x >> 8) & 15) << 1), 13);
            end
            7'h37, 7'h17: begin e.fmt = 3'd4; v = sx(x & 64'hFFFF_F000, 32); rel = (ir[6:0] == 7'h17); end
            7'h6F: begin
                e.fmt = 3'd5; rel = 1'b1;
                v = sx(((x >> 31) << 20) | (((x >> 12) & 255) << 12) | (((x >> 20) & 1) << 11)
                       | (((x >> 21) & 1023) << 1), 21);
            end
            7'h33: e.fmt = 3'd0;
            7'h3B: e.il = (xlen == 32);
            default: e.il = 1'b1;
        endcase
        e.imm = 64'(v) & mask;
        e.tg  = (rel ? (pc + 64'(v)) : (pc + 64'd4)) & mask;
        return e;
    endfunction

    task automatic model_step();
        if (!rst_n) begin
            for (int k = 0; k < 3; k++) begin cnt[k] = 0; rdyr[k] = 1'b1; end
        end else begin
            for (int k = 0; k < 3; k++) begin
                logic rdy;
                rdy = (k < 2) ? rdyr[k] : (cnt[k] == 0 || out_ready);
                if (flush) begin
                    cnt[k] = 0;
                end else begin
                    if (cnt[k] > 0 && out_ready) begin
                        for (int j = 0; j < 3; j++) mem[k][j] = mem[k][j+1];
                        cnt[k] = cnt[k] - 1;
                    end
                    if (in_valid && rdy) begin
                        mem[k][cnt[k]] = ref_model(in_ir, in_pc, (k == 1) ? 64 : 32);
                        cnt[k] = cnt[k] + 1;
                    end
                end
                if (k < 2) rdyr[k] = (cnt[k] < 2);
            end
        end
    endtask

    task automatic chk(string nm, int k, logic [63:0] act, logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s dut%0d got=%h expected=%h t=%0t", nm, k, act, exp, $time);
        end
    endtask

    task automatic cmp(int k);
        logic er;
        er = (k < 2) ? rdyr[k] : (cnt[k] == 0 || out_ready);
        chk("out_valid", k, 64'(a_val[k]), 64'(cnt[k] > 0));
        chk("in_ready", k, 64'(a_rdy[k]), 64'(er));
        if (cnt[k] > 0) begin
            chk("out_ir", k, 64'(a_ir[k]), 64'(mem[k][0].ir));
            chk("out_pc", k, a_pc[k], mem[k][0].pc);
            chk("out_imm", k, a_imm[k], mem[k][0].imm);
            chk("out_fmt", k, 64'(a_fmt[k]), 64'(mem[k][0].fmt));
            chk("out_target", k, a_tg[k], mem[k][0].tg);
            chk("out_illegal", k, 64'(a_il[k]), 64'(mem[k][0].il));
        end
    endtask

    task automatic reset_checks(string nm);
        for (int k = 0; k < 3; k++) begin
            chk({nm, "_valid"}, k, 64'(a_val[k]), 64'd0);
            chk({nm, "_ready"}, k, 64'(a_rdy[k]), 64'd1);
            chk({nm, "_imm"}, k, a_imm[k], 64'd0);
            chk({nm, "_fmt"}, k, 64'(a_fmt[k]), 64'd0);
            chk({nm, "_target"}, k, a_tg[k], 64'd0);
            chk({nm, "_ir_pc"}, k, {32'b0, a_ir[k]} | a_pc[k], 64'd0);
            chk({nm, "_illegal"}, k, 64'(a_il[k]), 64'd0);
        end
    endtask

    function automatic logic [31:0] rand_ir();
        logic [6:0]  ops [13] = '{7'h03, 7'h0F, 7'h13, 7'h17, 7'h1B, 7'h23, 7'h33,
                                  7'h37, 7'h3B, 7'h63, 7'h67, 7'h6F, 7'h73};
        logic [31:0] r;
        r = $urandom;
        if ($urandom_range(7) == 0) return r;
        return {r[31:7], ops[$urandom_range(12)]};
    endfunction

    initial forever begin
        @(posedge clk or negedge rst_n);
        model_step();
    end

    initial forever begin
        @(negedge clk);
        if (chk_en) for (int k = 0; k < 3; k++) cmp(k);
    end

    typedef struct {
        logic [31:0] ir;
        logic [63:0] pc;
        logic [63:0] imm32, imm64, tg32, tg64;
        logic [2:0]  f32, f64;
        logic        il32, il64;
    } vec_t;

    vec_t vt [11];
    int   n;
    logic acc;

    initial begin
        vt[0]  = '{32'hFFF00093, 64'h0,    64'hFFFFFFFF, 64'hFFFFFFFFFFFFFFFF, 64'h4,   64'h4,   3'd1, 3'd1, 1'b0, 1'b0};
        vt[1]  = '{32'hFE112E23, 64'h0,    64'hFFFFFFFC, 64'hFFFFFFFFFFFFFFFC, 64'h4,   64'h4,   3'd2, 3'd2, 1'b0, 1'b0};
        vt[2]  = '{32'hFE000CE3, 64'h100,  64'hFFFFFFF8, 64'hFFFFFFFFFFFFFFF8, 64'hF8,  64'hF8,  3'd3, 3'd3, 1'b0, 1'b0};
        vt[3]  = '{32'h0010006F, 64'h1000, 64'h800,      64'h800,              64'h1800,64'h1800,3'd5, 3'd5, 1'b0, 1'b0};
        vt[4]  = '{32'h800002B7, 64'h0,    64'h80000000, 64'hFFFFFFFF80000000, 64'h4,   64'h4,   3'd4, 3'd4, 1'b0, 1'b0};
        vt[5]  = '{32'h02809093, 64'h0,    64'h8,        64'h28,               64'h4,   64'h4,   3'd6, 3'd6, 1'b0, 1'b0};
        vt[6]  = '{32'h0000001B, 64'h0,    64'h0,        64'h0,                64'h4,   64'h4,   3'd0, 3'd1, 1'b1, 1'b0};
        vt[7]  = '{32'hFFFFF097, 64'h2000, 64'hFFFFF000, 64'hFFFFFFFFFFFFF000, 64'h1000,64'h1000,3'd4, 3'd4, 1'b0, 1'b0};
        vt[8]  = '{32'h00000000, 64'h0,    64'h0,        64'h0,                64'h4,   64'h4,   3'd0, 3'd0, 1'b1, 1'b1};
        vt[9]  = '{32'h01F0909B, 64'h0,    64'h0,        64'h1F,               64'h4,   64'h4,   3'd0, 3'd6, 1'b1, 1'b0};
        vt[10] = '{32'h00000013, 64'hFFFFFFFC, 64'h0,    64'h0,                64'h0,   64'h100000000, 3'd1, 3'd1, 1'b0, 1'b0};

        @(posedge clk);
        chk_en = 1'b1;
        @(negedge clk);
        reset_checks("reset");
        @(posedge clk); #1;
        rst_n = 1'b1;

        // Directed vectors, one accept each, results checked against literals
        for (int i = 0; i < 11; i++) begin
            @(posedge clk); #1;
            in_valid = 1'b1; in_ir = vt[i].ir; in_pc = vt[i].pc;
            @(posedge clk); #1;
            in_valid = 1'b0;
            @(negedge clk);
            for (int k = 0; k < 3; k++) begin
                chk("dir_imm", k, a_imm[k], (k == 1) ? vt[i].imm64 : vt[i].imm32);
                chk("dir_fmt", k, 64'(a_fmt[k]), 64'((k == 1) ? vt[i].f64 : vt[i].f32));
                chk("dir_illegal", k, 64'(a_il[k]), 64'((k == 1) ? vt[i].il64 : vt[i].il32));
                chk("dir_target", k, a_tg[k], (k == 1) ? vt[i].tg64 : vt[i].tg32);
            end
        end

        // Backpressure: four instructions against a stalled sink
        @(posedge clk); #1;
        out_ready = 1'b0;
        n = 0;
        for (int c = 0; c < 16 && n < 4; c++) begin
            in_valid = 1'b1;
            in_ir = 32'h00100093 + (n << 20);
            in_pc = 64'h400 + 64'(n * 4);
            acc = a_rdy[0];
            @(posedge clk); #1;
            if (acc) n++;
            if (c == 0) chk("bp_ready_after_1", 0, 64'(a_rdy[0]), 64'd1);
            if (c == 1) chk("bp_ready_after_2", 0, 64'(a_rdy[0]), 64'd0);
            if (c == 4) out_ready = 1'b1;
        end
        in_valid = 1'b0;
        chk("bp_accepted", 0, 64'(n), 64'd4);
        repeat (4) @(posedge clk);
        #1;

        // Flush while FULL with a competing input
        out_ready = 1'b0;
        in_valid  = 1'b1;
        repeat (3) begin
            in_ir = rand_ir();
            @(posedge clk); #1;
        end
        chk("fl_full_ready", 0, 64'(a_rdy[0]), 64'd0);
        flush = 1'b1; in_ir = 32'h0BAD0013;
        @(posedge clk); #1;
        flush = 1'b0; in_valid = 1'b0;
        chk("fl_valid", 0, 64'(a_val[0]), 64'd0);
        chk("fl_ready", 0, 64'(a_rdy[0]), 64'd1);
        chk("fl_valid", 1, 64'(a_val[1]), 64'd0);
        out_ready = 1'b1;
        repeat (3) @(posedge clk);

        // Random traffic with one asynchronous reset mid-stream
        for (int c = 0; c < 3000; c++) begin
            @(posedge clk); #1;
            in_valid  = ($urandom_range(9) < 7);
            out_ready = ($urandom_range(9) < 6);
            flush     = ($urandom_range(39) == 0);
            in_ir     = rand_ir();
            in_pc     = {$urandom, $urandom};
            if (c == 1500) begin
                #1 rst_n = 1'b0;
                #1 reset_checks("midreset");
                @(posedge clk); #1;
                rst_n = 1'b1;
            end
        end

        @(posedge clk); #1;
        in_valid = 1'b0;
        @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
